fp_accum_feeder: RTL and testbench
==================================

Name: fp_accum_feeder

Overview:
- Upstream sequencer for the float32 accumulator stage; owns its load/busy handshake and its clear.
- Buffers an incoming valid/ready stream of IEEE-754 single-precision samples in a small FIFO.
- On `start`, clears the accumulator and issues exactly `count` samples, one addition at a time.
- Captures the final sum and status and pulses `done`.

Parameters:
- DEPTH, 8, input FIFO depth in words; power of two, >= 2.
- CNT_W, 16, width of the run-length counter.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- s_data  in  32  float32 sample.
- s_valid  in  1  sample valid.
- s_ready  out  1  FIFO not full.
- start  in  1  begin run (single-cycle pulse).
- count  in  CNT_W  samples to sum in this run; sampled on `start`.
- run_busy  out  1  run in progress.
- done  out  1  one-cycle pulse; result valid.
- result  out  32  captured sum.
- result_status  out  1  captured status.
- fifo_level  out  $clog2(DEPTH)+1  FIFO occupancy.
- add_rstn  out  1  active-low clear to the accumulator.
- add_a  out  32  operand to the accumulator.
- add_load  out  1  load strobe to the accumulator.
- add_busy  in  1  accumulator busy.
- add_status  in  1  accumulator status.
- add_sum  in  32  accumulator output.

Behaviour:
- Reset (`resetn`=0 at a clk edge):
  - FIFO emptied; `fifo_level`=0, `s_ready`=0 during reset, 1 after.
  - State IDLE; `run_busy`=0, `done`=0, `result`=0, `result_status`=0.
  - `add_a`=0, `add_load`=0, `add_rstn`=0 (accumulator held clear).
  - Reset mid-run aborts the run silently; no `done`.
- FIFO:
  - Write when `s_valid` && `s_ready`.
  - Pop only in ISSUE.
  - Simultaneous push and pop keeps `fifo_level` constant.
  - Full: `s_ready`=0 and input is not accepted.
  - Pointers wrap modulo DEPTH.
  - FIFO accepts data in every state, including IDLE.
- FSM:
  - IDLE: `add_rstn`=1. On `start`: latch `count` into `remaining`, set `run_busy`=1, go to CLEAR.
  - CLEAR (1 cycle): `add_rstn`=0. If `remaining`==0 go to FINISH, else go to ISSUE.
  - ISSUE: wait for FIFO non-empty. Then:
    - drive `add_a`=head and `add_load`=1 for exactly one cycle;
    - pop the FIFO;
    - decrement `remaining`;
    - go to WAIT_ACK.
  - WAIT_ACK: wait for `add_busy`=1, then go to WAIT_DONE. If `add_busy` is still 0 after 4 cycles, go to WAIT_DONE anyway (tolerates zero-latency adds).
  - WAIT_DONE: wait for `add_busy`=0. Then go to ISSUE if `remaining`>0, else go to FINISH.
  - FINISH (1 cycle):
    - `result`<=`add_sum`, `result_status`<=`add_status`;
    - `done`=1;
    - `run_busy`=0 from the next cycle;
    - go to IDLE.
- Handshake and hold rules:
  - `add_a` holds its last value outside the load cycle.
  - `add_load` is never asserted while `add_busy`=1.
  - `start` is ignored while `run_busy`=1.
  - `count` changes during a run have no effect.
  - `result` holds until the next FINISH.
  - `add_rstn` deasserts one cycle after CLEAR.
  - `count`=0 yields `result`=0x00000000 and `done` 3 cycles after `start` (CLEAR, FINISH).
- Arithmetic: the block performs none. All summation is in the accumulator; the feeder only passes float32 bit patterns.
- Latency per sample: ISSUE 1 cycle + ack + adder latency + 1 cycle.

Optional Feature:
- Macro: FP_ACCUM_FEEDER_STICKY_STATUS_EN.
- Defined: a sticky flag is cleared in CLEAR and ORs `add_status` every WAIT_DONE exit cycle; `result_status` = sticky flag, i.e. any intermediate NaN/Inf/denormal is reported.
- Undefined: `result_status` = `add_status` sampled in FINISH only.

Test Plan:
- Push 0x3F800000, 0x40000000, 0x40400000 (1.0, 2.0, 3.0); `start` with `count`=3 -> exactly 3 `add_load` pulses carrying those values in order; `done` once; `result`=0x40C00000 (6.0).
- `start` with `count`=0 -> `add_rstn` low 1 cycle; `done` 3 cycles after `start`; `result`=0; no `add_load`.
- Fill FIFO with DEPTH words while IDLE -> `s_ready`=0 and `fifo_level`=DEPTH; a 9th `s_valid` beat is not accepted. Run `count`=DEPTH -> all consumed, `fifo_level`=0.
- `count`=2 with FIFO empty at `start`; feed 0x3F800000 10 cycles later and 0x3F800000 again later -> FSM waits in ISSUE; `result`=0x40000000.
- Reset asserted during WAIT_DONE of a 4-sample run -> no `done`; `fifo_level`=0; `add_rstn`=0. A new run of 0x3F800000 ×1 after reset -> `result`=0x3F800000.
- Samples 0x7F800000 (+Inf) then 0x3F800000 with the sticky macro defined -> `result_status`=1; also sum two samples where only the first add reports status: `result_status`=1 with the macro, equal to the final `add_status` without it.

Source files
------------

// File: rtl/fp_accum_feeder.sv
// Sequencer feeding a float32 accumulator: FIFO-buffered samples, clear, N loads, capture result.
// Optional FP_ACCUM_FEEDER_STICKY_STATUS_EN: result_status reports status raised by any add of the run.
module fp_accum_feeder #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [31:0]            s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic                   start,
    input  logic [CNT_W-1:0]       count,
    output logic                   run_busy,
    output logic                   done,
    output logic [31:0]            result,
    output logic                   result_status,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   add_rstn,
    output logic [31:0]            add_a,
    output logic                   add_load,
    input  logic                   add_busy,
    input  logic                   add_status,
    input  logic [31:0]            add_sum
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE, S_FINISH
    } state_t;

    logic [31:0]      mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             push, pop;
    logic [31:0]      head;

    state_t           state_q;
    logic [CNT_W-1:0] remaining_q;
    logic [1:0]       ack_cnt_q;
    logic             run_busy_q, done_q, result_status_q;
    logic             add_rstn_q, add_load_q;
    logic [31:0]      result_q, add_a_q;
`ifdef FP_ACCUM_FEEDER_STICKY_STATUS_EN
    logic             sticky_q;
`endif

    assign s_ready = resetn && (level_q != FULL_LEVEL);
    assign push    = s_valid && s_ready;
    // Only issue once the accumulator is idle so a load never overlaps busy.
    assign pop     = (state_q == S_ISSUE) && (level_q != '0) && !add_busy;
    assign head    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      level_d = level_q + 1'b1;
        else if (pop && !push) level_d = level_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= s_data;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q         <= S_IDLE;
            remaining_q     <= '0;
            ack_cnt_q       <= '0;
            run_busy_q      <= 1'b0;
            done_q          <= 1'b0;
            result_q        <= '0;
            result_status_q <= 1'b0;
            add_rstn_q      <= 1'b0;
            add_load_q      <= 1'b0;
            add_a_q         <= '0;
`ifdef FP_ACCUM_FEEDER_STICKY_STATUS_EN
            sticky_q        <= 1'b0;
`endif
        end else begin
            add_load_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    add_rstn_q <= 1'b1;
                    if (start) begin
                        remaining_q <= count;
                        run_busy_q  <= 1'b1;
                        add_rstn_q  <= 1'b0;
                        state_q     <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    add_rstn_q <= 1'b1;
`ifdef FP_ACCUM_FEEDER_STICKY_STATUS_EN
                    sticky_q   <= 1'b0;
`endif
                    state_q    <= (remaining_q == '0) ? S_FINISH : S_ISSUE;
                end
                S_ISSUE: begin
                    if (pop) begin
                        add_a_q     <= head;
                        add_load_q  <= 1'b1;
                        remaining_q <= remaining_q - 1'b1;
                        ack_cnt_q   <= '0;
                        state_q     <= S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    // Give up waiting for busy after four cycles: zero-latency adders never raise it.
                    if (add_busy || ack_cnt_q == 2'd3) state_q <= S_WAIT_DONE;
                    else ack_cnt_q <= ack_cnt_q + 1'b1;
                end
                S_WAIT_DONE: begin
                    if (!add_busy) begin
`ifdef FP_ACCUM_FEEDER_STICKY_STATUS_EN
                        sticky_q <= sticky_q | add_status;
`endif
                        state_q  <= (remaining_q != '0) ? S_ISSUE : S_FINISH;
                    end
                end
                S_FINISH: begin
                    result_q        <= add_sum;
`ifdef FP_ACCUM_FEEDER_STICKY_STATUS_EN
                    result_status_q <= sticky_q;
`else
                    result_status_q <= add_status;
`endif
                    done_q          <= 1'b1;
                    run_busy_q      <= 1'b0;
                    state_q         <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign run_busy      = run_busy_q;
    assign done          = done_q;
    assign result        = result_q;
    assign result_status = result_status_q;
    assign fifo_level    = level_q;
    assign add_rstn      = add_rstn_q;
    assign add_a         = add_a_q;
    assign add_load      = add_load_q;

endmodule

// File: tb/tb_fp_accum_feeder.sv
// Directed bench for fp_accum_feeder with a behavioural float32 accumulator model.
module tb_fp_accum_feeder;
    localparam int DEPTH = 8;
    localparam int CNT_W = 16;
    localparam int LAT   = 3;
`ifdef FP_ACCUM_FEEDER_STICKY_STATUS_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   resetn, s_valid, s_ready, start;
    logic [31:0]            s_data;
    logic [CNT_W-1:0]       count;
    logic                   run_busy, done, result_status;
    logic [31:0]            result;
    logic [$clog2(DEPTH):0] fifo_level;
    logic                   add_rstn, add_load;
    logic [31:0]            add_a;
    logic                   add_busy = 1'b0;
    logic                   add_status = 1'b0;
    logic [31:0]            add_sum = 32'h0;

    fp_accum_feeder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .resetn(resetn),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .start(start), .count(count),
        .run_busy(run_busy), .done(done), .result(result), .result_status(result_status),
        .fifo_level(fifo_level),
        .add_rstn(add_rstn), .add_a(add_a), .add_load(add_load),
        .add_busy(add_busy), .add_status(add_status), .add_sum(add_sum)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Accumulator model: float32 add via real arithmetic, status on Inf/NaN/denormal operand.
    real acc_r    = 0.0;
    bit  acc_inf  = 1'b0;
    int  lat_cnt  = 0;
    bit  zero_lat = 1'b0;
    logic [31:0] pend_a;

    function automatic real f32_to_real(input logic [31:0] a);
        int e;
        e = int'(a[30:23]) - 127 + 1023;
        return $bitstoreal({a[31], 11'(e), a[22:0], 29'b0});
    endfunction

    function automatic logic [31:0] real_to_f32(input real r);
        logic [63:0] b;
        int e;
        if (r == 0.0) return 32'h0;
        b = $realtobits(r);
        e = int'(b[62:52]) - 1023 + 127;
        return {b[63], 8'(e), b[51:29]};
    endfunction

    function automatic bit acc_add(input logic [31:0] a);
        if (a[30:23] == 8'hFF) begin
            acc_inf = 1'b1;
            return 1'b1;
        end
        if (a[30:23] == 8'h00) return (a[22:0] != 0);
        acc_r = acc_r + f32_to_real(a);
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        bit st;
        if (!add_rstn) begin
            acc_r = 0.0; acc_inf = 1'b0; lat_cnt = 0;
            add_busy <= 1'b0; add_status <= 1'b0; add_sum <= 32'h0;
        end else if (add_load) begin
            pend_a = add_a;
            if (zero_lat) begin
                st = acc_add(pend_a);
                add_status <= st;
                add_sum <= acc_inf ? 32'h7F800000 : real_to_f32(acc_r);
            end else begin
                lat_cnt = LAT;
                add_busy <= 1'b1;
            end
        end else if (lat_cnt > 0) begin
            lat_cnt--;
            if (lat_cnt == 0) begin
                st = acc_add(pend_a);
                add_status <= st;
                add_sum <= acc_inf ? 32'h7F800000 : real_to_f32(acc_r);
                add_busy <= 1'b0;
            end
        end
    end

    logic [31:0] load_q[$];
    int done_cnt = 0;
    int rstn_low_cnt = 0;

    always @(negedge clk) begin
        if (resetn) begin
            if (add_load) begin
                load_q.push_back(add_a);
                chk("load_while_busy", add_busy, 1'b0);
            end
            if (done) done_cnt++;
            if (!add_rstn) rstn_low_cnt++;
        end
    end

    function automatic logic [31:0] load_at(input int i);
        return (i < load_q.size()) ? load_q[i] : 32'hDEADBEEF;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        s_data = w; s_valid = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic go(input int n);
        count = CNT_W'(n); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < budget);
        chk(tag, done, 1'b1);
        @(posedge clk); #1;
    endtask

    logic [31:0] vals [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                              32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};

    initial begin
        int cyc, d0, r0, n;
        resetn = 1'b0; s_valid = 1'b0; s_data = '0; start = 1'b0; count = '0;
        tick(3);
        chk("rst_s_ready", s_ready, 1'b0);
        chk("rst_level", fifo_level, 0);
        chk("rst_run_busy", run_busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_result", result, 32'h0);
        chk("rst_status", result_status, 1'b0);
        chk("rst_add_rstn", add_rstn, 1'b0);
        chk("rst_add_load", add_load, 1'b0);
        chk("rst_add_a", add_a, 32'h0);
        resetn = 1'b1;
        tick(1);
        chk("post_rst_s_ready", s_ready, 1'b1);
        chk("post_rst_add_rstn", add_rstn, 1'b1);
        $display("reset: checks=%0d errors=%0d", checks, errors);

        // 1.0 + 2.0 + 3.0
        for (int i = 0; i < 3; i++) push(vals[i]);
        chk("t1_level", fifo_level, 3);
        load_q.delete(); d0 = done_cnt;
        go(3);
        wait_done("t1_done_timeout", 200, cyc);
        tick(2);
        chk("t1_nloads", load_q.size(), 3);
        for (int i = 0; i < 3; i++) chk($sformatf("t1_load%0d", i), load_at(i), vals[i]);
        chk("t1_result", result, 32'h40C00000);
        chk("t1_done_once", done_cnt - d0, 1);
        chk("t1_run_busy", run_busy, 1'b0);
        chk("t1_level_end", fifo_level, 0);
        $display("run count=3: result=%h", result);

        // count = 0
        load_q.delete(); d0 = done_cnt; r0 = rstn_low_cnt;
        go(0);
        wait_done("t2_done_timeout", 20, cyc);
        chk("t2_latency", cyc, 3);
        chk("t2_result", result, 32'h0);
        chk("t2_rstn_low_cycles", rstn_low_cnt - r0, 1);
        chk("t2_nloads", load_q.size(), 0);
        chk("t2_run_busy", run_busy, 1'b0);
        tick(2);
        chk("t2_done_once", done_cnt - d0, 1);
        $display("run count=0: done after %0d cycles", cyc);

        // fill FIFO while idle, overflow beat refused
        for (int i = 0; i < DEPTH; i++) push(vals[i]);
        chk("t3_level_full", fifo_level, DEPTH);
        chk("t3_s_ready_full", s_ready, 1'b0);
        push(32'h41100000);
        chk("t3_level_after_extra", fifo_level, DEPTH);
        load_q.delete();
        go(DEPTH);
        wait_done("t3_done_timeout", 400, cyc);
        chk("t3_nloads", load_q.size(), DEPTH);
        for (int i = 0; i < DEPTH; i++) chk($sformatf("t3_load%0d", i), load_at(i), vals[i]);
        chk("t3_result", result, 32'h42100000);
        chk("t3_level_end", fifo_level, 0);
        chk("t3_s_ready_end", s_ready, 1'b1);
        $display("run count=8: result=%h", result);

        // FIFO empty at start; late samples; a start during the run is ignored
        load_q.delete(); d0 = done_cnt;
        go(2);
        tick(10);
        chk("t4_busy_waiting", run_busy, 1'b1);
        chk("t4_no_load_yet", load_q.size(), 0);
        go(5);
        tick(3);
        push(32'h3F800000);
        tick(10);
        chk("t4_one_load", load_q.size(), 1);
        push(32'h3F800000);
        wait_done("t4_done_timeout", 200, cyc);
        chk("t4_result", result, 32'h40000000);
        chk("t4_nloads", load_q.size(), 2);
        tick(20);
        chk("t4_done_once", done_cnt - d0, 1);
        chk("t4_idle", run_busy, 1'b0);
        $display("late feed run: result=%h", result);

        // reset in WAIT_DONE of a 4-sample run
        for (int i = 0; i < 4; i++) push(vals[i]);
        load_q.delete(); d0 = done_cnt;
        go(4);
        n = 0;
        while (!(load_q.size() >= 2 && add_busy) && n < 200) begin
            tick(1);
            n++;
        end
        chk("t5_reached_second_add", n < 200, 1'b1);
        tick(1);
        resetn = 1'b0;
        tick(1);
        chk("t5_level_cleared", fifo_level, 0);
        chk("t5_add_rstn", add_rstn, 1'b0);
        chk("t5_run_busy", run_busy, 1'b0);
        tick(1);
        resetn = 1'b1;
        tick(20);
        chk("t5_no_done", done_cnt - d0, 0);
        push(32'h3F800000);
        load_q.delete();
        go(1);
        wait_done("t5_done_timeout", 100, cyc);
        chk("t5_result", result, 32'h3F800000);
        chk("t5_nloads", load_q.size(), 1);
        $display("abort and rerun: result=%h", result);

        // status: +Inf then 1.0
        push(32'h7F800000); push(32'h3F800000);
        go(2);
        wait_done("t6_done_timeout", 100, cyc);
        chk("t6_result", result, 32'h7F800000);
        chk("t6_status", result_status, STICKY);
        $display("inf run: result=%h status=%0d", result, result_status);

        // status: denormal first, only first add flags
        push(32'h00000001); push(32'h3F800000);
        go(2);
        wait_done("t7_done_timeout", 100, cyc);
        chk("t7_result", result, 32'h3F800000);
        chk("t7_status", result_status, STICKY);
        $display("denormal-first run: result=%h status=%0d", result, result_status);

        // status raised by the final add only
        push(32'h3F800000); push(32'h7F800000);
        go(2);
        wait_done("t8_done_timeout", 100, cyc);
        chk("t8_result", result, 32'h7F800000);
        chk("t8_status", result_status, 1'b1);
        $display("inf-last run: result=%h status=%0d", result, result_status);

        // zero-latency accumulator: busy never rises
        zero_lat = 1'b1;
        load_q.delete();
        push(32'h40000000); push(32'h40400000);
        go(2);
        wait_done("t9_done_timeout", 100, cyc);
        chk("t9_result", result, 32'h40A00000);
        chk("t9_nloads", load_q.size(), 2);
        chk("t9_status", result_status, 1'b0);
        zero_lat = 1'b0;
        $display("zero-latency run: result=%h", result);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
